// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Registered RISC-V immediate generator for the decode stage. An instruction
//   word and its sideband tag (normally the PC) arrive over a valid/ready
//   handshake. The immediate, format code and illegal flag are decoded
//   combinationally on the input side and registered, so results appear one
//   clock after acceptance. A second (skid) entry gives one instruction per
//   clock under backpressure while keeping in_ready a pure flop output.
//
// Parameters
//   XLEN   immediate width, 32 or 64 (anything else stops elaboration)
//   TAG_W  width of the tag sideband, carried through untouched
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   flush                   synchronous drop of every buffered entry
//   in_valid/in_ready       input handshake (in_ready registered)
//   in_inst, in_tag         instruction word and its tag
//   out_valid/out_ready     output handshake
//   out_imm                 sign/zero-extended immediate
//   out_fmt                 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
//   out_illegal             opcode could not be decoded
//   out_tag                 tag travelling with the instruction on out_*
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_MAIN,
        ST_SKID
    } state_t;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam bit IS_RV64 = (XLEN == 64);

    // Decoded view of the instruction currently on in_inst
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [6:0]      opcode;
    logic [2:0]      funct3;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // Sign extension relies on sizing a $signed() operand up to XLEN.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            unique case (opcode)
                OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_inst[31:20]));
                end
                OPC_OP_IMM_32: begin
                    if (IS_RV64) begin
                        dec_fmt = FMT_I;
                        dec_imm = XLEN'($signed(in_inst[31:20]));
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    dec_fmt = FMT_S;
                    dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                end
                OPC_BRANCH: begin
                    dec_fmt = FMT_B;
                    dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                             in_inst[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt = FMT_U;
                    dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
                end
                OPC_JAL: begin
                    dec_fmt = FMT_J;
                    dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                             in_inst[30:21], 1'b0}));
                end
                OPC_SYSTEM: begin
                    // funct3 5..7 are the CSR immediate forms; 4 is unassigned
                    if (funct3 >= 3'd5) begin
                        dec_fmt = FMT_Z;
                        dec_imm = XLEN'(in_inst[19:15]);
                    end else if (funct3 == 3'd4) begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_OP, OPC_MISC_MEM: begin
                end
                OPC_OP_32: begin
                    dec_illegal = !IS_RV64;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    state_t          state_q, state_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic [2:0]      main_fmt_q, main_fmt_d;
    logic            main_ill_q, main_ill_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]      skid_fmt_q, skid_fmt_d;
    logic            skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic in_fire;
    logic out_fire;

    // Both handshake outputs come straight from the state flop.
    assign in_ready    = (state_q != ST_SKID);
    assign out_valid   = (state_q != ST_EMPTY);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;
    assign out_tag     = main_tag_q;

    // Next-state logic. The main entry is what drives out_*; it only changes
    // when it is empty or being consumed, which keeps out_* stable under stall.
    // Flush wins over any accept in the same clock.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        main_ill_d = main_ill_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d    = ST_MAIN;
                        main_imm_d = dec_imm;
                        main_fmt_d = dec_fmt;
                        main_ill_d = dec_illegal;
                        main_tag_d = in_tag;
                    end
                end
                ST_MAIN: begin
                    if (in_fire && out_fire) begin
                        main_imm_d = dec_imm;
                        main_fmt_d = dec_fmt;
                        main_ill_d = dec_illegal;
                        main_tag_d = in_tag;
                    end else if (in_fire) begin
                        state_d    = ST_SKID;
                        skid_imm_d = dec_imm;
                        skid_fmt_d = dec_fmt;
                        skid_ill_d = dec_illegal;
                        skid_tag_d = in_tag;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d    = ST_MAIN;
                        main_imm_d = skid_imm_q;
                        main_fmt_d = skid_fmt_q;
                        main_ill_d = skid_ill_q;
                        main_tag_d = skid_tag_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_imm_q <= '0;
            main_fmt_q <= FMT_NONE;
            main_ill_q <= 1'b0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= FMT_NONE;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_fmt_q <= main_fmt_d;
            main_ill_q <= main_ill_d;
            main_tag_q <= main_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
        end
    end

endmodule
